// File: rtl/minisys_mem_pkg.sv
// Shared memory-subsystem definitions for minisys: RAM geometry, owner and
// arbiter state encodings, and the per-cycle data-port grant decision.
package minisys_mem_pkg;

   localparam int RAM_ADDR_W = 16;
   localparam int WSTRB_W    = 4;
   localparam int DATA_W     = 32;
   localparam int STREAK_W   = 4;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DMA  = 2'd2
   } arb_owner_e;

   typedef enum logic {
      ARB_IDLE    = 1'b0,
      ARB_CPU_RET = 1'b1
   } arb_state_e;

   // CPU has fixed priority unless it is locked out, its read is returning,
   // or it has used up its streak while DMA waits.
   function automatic arb_owner_e pick_owner(
      input logic cpu_slot_open,
      input logic cpu_req,
      input logic dma_lock,
      input logic dma_req,
      input logic streak_full
   );
      arb_owner_e owner;
      owner = OWN_NONE;
      if (cpu_slot_open && cpu_req && !dma_lock && !(dma_req && streak_full)) begin
         owner = OWN_CPU;
      end else if (dma_req) begin
         owner = OWN_DMA;
      end
      return owner;
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU data port, the DMA/loader port and the shared RAM port.
// The arbiter uses the slave view; CPU, DMA and RAM models use the master view.
interface dmem_arbiter_if
   import minisys_mem_pkg::*;
#(
   parameter int ADDR_W = RAM_ADDR_W
);

   logic                 cpu_req;
   logic                 cpu_we;
   logic [WSTRB_W-1:0]   cpu_wstrb;
   logic [ADDR_W-1:0]    cpu_addr;
   logic [DATA_W-1:0]    cpu_wdata;
   logic [DATA_W-1:0]    cpu_rdata;
   logic                 cpu_stall;

   logic                 dma_lock;
   logic                 dma_req;
   logic                 dma_we;
   logic [WSTRB_W-1:0]   dma_wstrb;
   logic [ADDR_W-1:0]    dma_addr;
   logic [DATA_W-1:0]    dma_wdata;
   logic                 dma_gnt;
   logic                 dma_rvalid;
   logic [DATA_W-1:0]    dma_rdata;

   logic                 ram_en;
   logic [WSTRB_W-1:0]   ram_we;
   logic [ADDR_W-3:0]    ram_addr;
   logic [DATA_W-1:0]    ram_wdata;
   logic [DATA_W-1:0]    ram_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_wstrb, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_stall,
      input  dma_lock, dma_req, dma_we, dma_wstrb, dma_addr, dma_wdata,
      output dma_gnt, dma_rvalid, dma_rdata,
      output ram_en, ram_we, ram_addr, ram_wdata,
      input  ram_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_wstrb, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_stall,
      output dma_lock, dma_req, dma_we, dma_wstrb, dma_addr, dma_wdata,
      input  dma_gnt, dma_rvalid, dma_rdata,
      input  ram_en, ram_we, ram_addr, ram_wdata,
      output ram_rdata
   );

endinterface

// File: rtl/dmem_arbiter.sv
// Shares the synchronous data RAM between the CPU data port and the DMA/loader
// port: fixed CPU priority, read-return stall sequencing and a DMA starvation guard.
module dmem_arbiter
   import minisys_mem_pkg::*;
#(
   parameter int ADDR_W         = RAM_ADDR_W,
   parameter int MAX_CPU_STREAK = 4
) (
   input  logic            clk,
   input  logic            rst,
   dmem_arbiter_if.slave   bus
);

   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_CPU_STREAK);

   arb_state_e           state_reg;
   arb_state_e           state_next;
   logic [STREAK_W-1:0]  streak_reg;
   logic [STREAK_W-1:0]  streak_next;
   logic [DATA_W-1:0]    cpu_rdata_reg;
   logic                 dma_pend_reg;
   logic [DATA_W-1:0]    dma_rdata_reg;

   arb_owner_e           owner;
   logic                 in_ret;
   logic                 sel_en;
   logic                 sel_we;
   logic [WSTRB_W-1:0]   sel_wstrb;
   logic [ADDR_W-3:0]    sel_addr;
   logic [DATA_W-1:0]    sel_wdata;
   logic [WSTRB_W-1:0]   lane_we;

   assign in_ret = (state_reg == ARB_CPU_RET);

   // Grants are also gated by rst so every output drops the moment reset asserts.
   always_comb begin
      owner = OWN_NONE;
      if (rst) begin
         owner = pick_owner(!in_ret, bus.cpu_req, bus.dma_lock, bus.dma_req,
                            streak_reg == STREAK_MAX);
      end
   end

   always_comb begin
      sel_en    = 1'b0;
      sel_we    = 1'b0;
      sel_wstrb = '0;
      sel_addr  = '0;
      sel_wdata = '0;
      case (owner)
         OWN_CPU: begin
            sel_en    = 1'b1;
            sel_we    = bus.cpu_we;
            sel_wstrb = bus.cpu_wstrb;
            sel_addr  = bus.cpu_addr[ADDR_W-1:2];
            sel_wdata = bus.cpu_wdata;
         end
         OWN_DMA: begin
            sel_en    = 1'b1;
            sel_we    = bus.dma_we;
            sel_wstrb = bus.dma_wstrb;
            sel_addr  = bus.dma_addr[ADDR_W-1:2];
            sel_wdata = bus.dma_wdata;
         end
         default: begin
            sel_en = 1'b0;
         end
      endcase
   end

   for (genvar gi = 0; gi < WSTRB_W; gi++) begin : g_lane
      assign lane_we[gi] = sel_en & sel_we & sel_wstrb[gi];
   end

   assign bus.ram_en    = sel_en;
   assign bus.ram_we    = lane_we;
   assign bus.ram_addr  = sel_addr;
   assign bus.ram_wdata = sel_wdata;

   // A granted write retires this cycle; a granted read or a lost request holds
   // the CPU. During the return cycle the still-held request is the one completing.
   assign bus.cpu_stall = rst && !in_ret && bus.cpu_req &&
                          !((owner == OWN_CPU) && bus.cpu_we);
   assign bus.cpu_rdata = in_ret ? bus.ram_rdata : cpu_rdata_reg;

   assign bus.dma_gnt    = (owner == OWN_DMA);
   assign bus.dma_rvalid = dma_pend_reg;
   assign bus.dma_rdata  = dma_pend_reg ? bus.ram_rdata : dma_rdata_reg;

   always_comb begin
      state_next = ARB_IDLE;
      if ((owner == OWN_CPU) && !bus.cpu_we) begin
         state_next = ARB_CPU_RET;
      end
   end

   // The streak only counts CPU wins that DMA actually had to wait through.
   always_comb begin
      streak_next = streak_reg;
      if (!bus.dma_req || (owner == OWN_DMA)) begin
         streak_next = '0;
      end else if ((owner == OWN_CPU) && (streak_reg != STREAK_MAX)) begin
         streak_next = streak_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= ARB_IDLE;
         streak_reg    <= '0;
         cpu_rdata_reg <= '0;
         dma_pend_reg  <= 1'b0;
         dma_rdata_reg <= '0;
      end else begin
         state_reg    <= state_next;
         streak_reg   <= streak_next;
         dma_pend_reg <= (owner == OWN_DMA) && !bus.dma_we;
         if (in_ret) begin
            cpu_rdata_reg <= bus.ram_rdata;
         end
         if (dma_pend_reg) begin
            dma_rdata_reg <= bus.ram_rdata;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: table of single-cycle vectors plus
// hand-written multi-cycle sequences, read returns checked through a scoreboard.
module tb_dmem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   dmem_arbiter_if #(.ADDR_W(16)) bus();

   dmem_arbiter #(
      .ADDR_W         (16),
      .MAX_CPU_STREAK (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] pat(input int w);
      return (w == 4) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(w));
   endfunction

   // Synchronous RAM model: one-cycle read latency, byte-lane writes.
   logic [31:0] ram [0:16383];
   initial begin : ram_model
      for (int i = 0; i < 16384; i++) ram[i] = pat(i);
      bus.ram_rdata = '0;
      forever begin
         @(posedge clk);
         if (bus.ram_en) begin
            for (int b = 0; b < 4; b++)
               if (bus.ram_we[b]) ram[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
            if (bus.ram_we == 4'b0) bus.ram_rdata <= ram[bus.ram_addr];
         end
      end
   end

   logic [31:0] exp_mem [0:16383];

   typedef struct {
      int          due;
      logic [31:0] data;
   } sb_t;
   sb_t cq[$];
   sb_t dq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor: read data is compared in the cycle it is due.
   bit   mon_en = 1'b0;
   logic exp_dv;
   always @(negedge clk) begin
      if (mon_en) begin
         exp_dv = (dq.size() > 0) && (dq[0].due == cyc);
         chk("dma_rvalid", 32'(bus.dma_rvalid), 32'(exp_dv));
         if (exp_dv) begin
            chk("dma_rdata", bus.dma_rdata, dq[0].data);
            $display("dma read return 0x%08h", bus.dma_rdata);
            void'(dq.pop_front());
         end
         if ((cq.size() > 0) && (cq[0].due == cyc)) begin
            chk("cpu_rdata", bus.cpu_rdata, cq[0].data);
            chk("cpu_ret_stall", 32'(bus.cpu_stall), 32'd0);
            $display("cpu read return 0x%08h", bus.cpu_rdata);
            void'(cq.pop_front());
         end
      end
   end

   task automatic push_cpu(input logic [31:0] d);
      sb_t e;
      e.due  = cyc + 1;
      e.data = d;
      cq.push_back(e);
   endtask

   task automatic push_dma(input logic [31:0] d);
      sb_t e;
      e.due  = cyc + 1;
      e.data = d;
      dq.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic clr();
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_wstrb = '0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.dma_lock = 1'b0; bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_wstrb = '0;
      bus.dma_addr = '0; bus.dma_wdata = '0;
   endtask

   task automatic cpu_read(input logic [15:0] a, input logic [31:0] exp);
      step(); clr();
      bus.cpu_req = 1'b1; bus.cpu_addr = a;
      push_cpu(exp);
      smp();
      chk("rd_en", 32'(bus.ram_en), 32'd1);
      chk("rd_addr", 32'(bus.ram_addr), 32'(a[15:2]));
      chk("rd_stall", 32'(bus.cpu_stall), 32'd1);
      step(); smp();
   endtask

   task automatic dma_read(input logic [15:0] a, input logic [31:0] exp);
      step(); clr();
      bus.dma_req = 1'b1; bus.dma_addr = a;
      push_dma(exp);
      smp();
      chk("drd_gnt", 32'(bus.dma_gnt), 32'd1);
      chk("drd_addr", 32'(bus.ram_addr), 32'(a[15:2]));
      step(); clr(); smp();
   endtask

   typedef struct {
      logic        creq, cwe;
      logic [3:0]  cstrb;
      logic [15:0] caddr;
      logic [31:0] cwdata;
      logic        lock, dreq, dwe;
      logic [3:0]  dstrb;
      logic [15:0] daddr;
      logic [31:0] dwdata;
      logic        e_en;
      logic [3:0]  e_we;
      logic [13:0] e_addr;
      logic [31:0] e_wdata;
      logic        e_stall, e_gnt, e_cret, e_dret;
   } vec_t;

   function automatic vec_t mk(
      input logic creq, cwe, input logic [3:0] cstrb, input logic [15:0] caddr, input logic [31:0] cwdata,
      input logic lock, dreq, dwe, input logic [3:0] dstrb, input logic [15:0] daddr, input logic [31:0] dwdata,
      input logic e_en, input logic [3:0] e_we, input logic [13:0] e_addr, input logic [31:0] e_wdata,
      input logic e_stall, e_gnt, e_cret, e_dret);
      vec_t v;
      v.creq = creq; v.cwe = cwe; v.cstrb = cstrb; v.caddr = caddr; v.cwdata = cwdata;
      v.lock = lock; v.dreq = dreq; v.dwe = dwe; v.dstrb = dstrb; v.daddr = daddr; v.dwdata = dwdata;
      v.e_en = e_en; v.e_we = e_we; v.e_addr = e_addr; v.e_wdata = e_wdata;
      v.e_stall = e_stall; v.e_gnt = e_gnt; v.e_cret = e_cret; v.e_dret = e_dret;
      return v;
   endfunction

   localparam int NVEC = 14;
   vec_t vecs [NVEC];

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int idx;
      for (int i = 0; i < 16384; i++) exp_mem[i] = pat(i);

      //                creq cwe strb   caddr     cwdata          lk dreq dwe strb  daddr     dwdata          en we    addr    wdata         st gnt cret dret
      vecs[0]  = mk(1, 0, 4'h0, 16'h0010, 32'h0,          0, 0, 0, 4'h0, 16'h0000, 32'h0,          1, 4'h0, 14'd4,  32'h0,          1, 0, 1, 0);
      vecs[1]  = mk(1, 1, 4'h3, 16'h0020, 32'h12345678,   0, 0, 0, 4'h0, 16'h0000, 32'h0,          1, 4'h3, 14'd8,  32'h12345678,   0, 0, 0, 0);
      vecs[2]  = mk(1, 0, 4'h0, 16'h0020, 32'h0,          0, 0, 0, 4'h0, 16'h0000, 32'h0,          1, 4'h0, 14'd8,  32'h0,          1, 0, 1, 0);
      vecs[3]  = mk(0, 0, 4'h0, 16'h0000, 32'h0,          0, 1, 1, 4'hF, 16'h0104, 32'h11223344,   1, 4'hF, 14'h41, 32'h11223344,   0, 1, 0, 0);
      vecs[4]  = mk(0, 0, 4'h0, 16'h0000, 32'h0,          0, 1, 1, 4'h8, 16'h0104, 32'h99000000,   1, 4'h8, 14'h41, 32'h99000000,   0, 1, 0, 0);
      vecs[5]  = mk(0, 0, 4'h0, 16'h0000, 32'h0,          0, 1, 0, 4'h0, 16'h0104, 32'h0,          1, 4'h0, 14'h41, 32'h0,          0, 1, 0, 1);
      vecs[6]  = mk(1, 0, 4'hF, 16'h0024, 32'hFFFFFFFF,   0, 1, 0, 4'h0, 16'h0010, 32'h0,          1, 4'h0, 14'd9,  32'hFFFFFFFF,   1, 0, 1, 0);
      vecs[7]  = mk(1, 1, 4'hF, 16'h0030, 32'hAAAA0000,   0, 1, 1, 4'hF, 16'h0030, 32'h0000BBBB,   1, 4'hF, 14'd12, 32'hAAAA0000,   0, 0, 0, 0);
      vecs[8]  = mk(0, 0, 4'h0, 16'h0000, 32'h0,          0, 1, 1, 4'hF, 16'h0030, 32'h0000BBBB,   1, 4'hF, 14'd12, 32'h0000BBBB,   0, 1, 0, 0);
      vecs[9]  = mk(1, 0, 4'h0, 16'h0030, 32'h0,          0, 0, 0, 4'h0, 16'h0000, 32'h0,          1, 4'h0, 14'd12, 32'h0,          1, 0, 1, 0);
      vecs[10] = mk(1, 1, 4'hF, 16'h0040, 32'h01010101,   1, 1, 1, 4'hF, 16'h0044, 32'h00000077,   1, 4'hF, 14'd17, 32'h00000077,   1, 1, 0, 0);
      vecs[11] = mk(1, 0, 4'h0, 16'h0010, 32'h0,          1, 0, 0, 4'h0, 16'h0000, 32'h0,          0, 4'h0, 14'd0,  32'h0,          1, 0, 0, 0);
      vecs[12] = mk(0, 0, 4'h0, 16'h0000, 32'h0,          0, 0, 0, 4'h0, 16'h0000, 32'h0,          0, 4'h0, 14'd0,  32'h0,          0, 0, 0, 0);
      vecs[13] = mk(0, 0, 4'h0, 16'h0000, 32'h0,          0, 1, 0, 4'h0, 16'h0044, 32'h0,          1, 4'h0, 14'd17, 32'h0,          0, 1, 0, 1);

      // Reset state
      clr();
      smp();
      chk("rst_stall", 32'(bus.cpu_stall), 32'd0);
      chk("rst_ram_en", 32'(bus.ram_en), 32'd0);
      chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
      chk("rst_dma_gnt", 32'(bus.dma_gnt), 32'd0);
      chk("rst_dma_rvalid", 32'(bus.dma_rvalid), 32'd0);
      chk("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
      chk("rst_dma_rdata", bus.dma_rdata, 32'd0);
      step(); step();
      rst = 1'b1;
      mon_en = 1'b1;

      // Table of independent single-cycle vectors, each followed by a settle cycle
      for (int i = 0; i < NVEC; i++) begin
         step(); clr();
         bus.cpu_req = vecs[i].creq; bus.cpu_we = vecs[i].cwe; bus.cpu_wstrb = vecs[i].cstrb;
         bus.cpu_addr = vecs[i].caddr; bus.cpu_wdata = vecs[i].cwdata;
         bus.dma_lock = vecs[i].lock; bus.dma_req = vecs[i].dreq; bus.dma_we = vecs[i].dwe;
         bus.dma_wstrb = vecs[i].dstrb; bus.dma_addr = vecs[i].daddr; bus.dma_wdata = vecs[i].dwdata;
         if (vecs[i].e_cret) push_cpu(exp_mem[vecs[i].e_addr]);
         if (vecs[i].e_dret) push_dma(exp_mem[vecs[i].e_addr]);
         smp();
         chk($sformatf("v%0d_ram_en", i), 32'(bus.ram_en), 32'(vecs[i].e_en));
         chk($sformatf("v%0d_ram_we", i), 32'(bus.ram_we), 32'(vecs[i].e_we));
         chk($sformatf("v%0d_stall", i), 32'(bus.cpu_stall), 32'(vecs[i].e_stall));
         chk($sformatf("v%0d_gnt", i), 32'(bus.dma_gnt), 32'(vecs[i].e_gnt));
         if (vecs[i].e_en) begin
            chk($sformatf("v%0d_ram_addr", i), 32'(bus.ram_addr), 32'(vecs[i].e_addr));
            chk($sformatf("v%0d_ram_wdata", i), bus.ram_wdata, vecs[i].e_wdata);
            for (int b = 0; b < 4; b++)
               if (vecs[i].e_we[b]) exp_mem[vecs[i].e_addr][8*b +: 8] = vecs[i].e_wdata[8*b +: 8];
         end
         step();
         if (vecs[i].e_cret) begin
            bus.dma_req = 1'b0; bus.dma_lock = 1'b0;
         end else begin
            clr();
         end
         smp();
         chk($sformatf("v%0d_after_en", i), 32'(bus.ram_en), 32'd0);
         chk($sformatf("v%0d_after_stall", i), 32'(bus.cpu_stall), 32'd0);
         $display("vector %0d applied", i);
      end

      // DMA read issued in the CPU return cycle
      step(); clr();
      bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0010;
      push_cpu(32'hDEADBEEF);
      smp();
      chk("ret_issue_stall", 32'(bus.cpu_stall), 32'd1);
      step();
      bus.dma_req = 1'b1; bus.dma_addr = 16'h0020;
      push_dma(exp_mem[8]);
      smp();
      chk("ret_dma_gnt", 32'(bus.dma_gnt), 32'd1);
      chk("ret_cpu_stall", 32'(bus.cpu_stall), 32'd0);
      chk("ret_dma_addr", 32'(bus.ram_addr), 32'd8);
      step(); clr(); smp();
      $display("cpu return with dma issue done");

      // Streak guard: CPU writes back-to-back while DMA waits
      idx = 0;
      for (int c = 0; c < 10; c++) begin
         step(); clr();
         bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_wstrb = 4'hF;
         bus.cpu_addr = 16'h0200 + 16'(4 * idx); bus.cpu_wdata = 32'h77000000 + 32'(idx);
         bus.dma_req = (c <= 4); bus.dma_we = 1'b1; bus.dma_wstrb = 4'hF;
         bus.dma_addr = 16'h0100; bus.dma_wdata = 32'hA5A5A5A5;
         smp();
         chk($sformatf("streak_gnt_c%0d", c), 32'(bus.dma_gnt), 32'(c == 4));
         chk($sformatf("streak_stall_c%0d", c), 32'(bus.cpu_stall), 32'(c == 4));
         if (c == 4) begin
            exp_mem[64] = 32'hA5A5A5A5;
         end else begin
            exp_mem[128 + idx] = 32'h77000000 + 32'(idx);
            idx++;
         end
      end
      step(); clr(); smp();
      cpu_read(16'h0100, exp_mem[64]);
      cpu_read(16'h0210, exp_mem[132]);
      $display("streak sequence done");

      // dma_lock: CPU excluded while DMA streams writes
      for (int c = 0; c < 10; c++) begin
         step(); clr();
         bus.dma_lock = 1'b1;
         bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0010;
         bus.dma_req = (c < 8); bus.dma_we = 1'b1; bus.dma_wstrb = 4'hF;
         bus.dma_addr = 16'h0300 + 16'(4 * c); bus.dma_wdata = 32'h50000000 + 32'(c);
         smp();
         chk($sformatf("lock_stall_c%0d", c), 32'(bus.cpu_stall), 32'd1);
         chk($sformatf("lock_gnt_c%0d", c), 32'(bus.dma_gnt), 32'(c < 8));
         if (c < 8) exp_mem[192 + c] = 32'h50000000 + 32'(c);
      end
      step(); clr();
      bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0010;
      push_cpu(32'hDEADBEEF);
      smp();
      chk("unlock_en", 32'(bus.ram_en), 32'd1);
      chk("unlock_addr", 32'(bus.ram_addr), 32'd4);
      chk("unlock_stall", 32'(bus.cpu_stall), 32'd1);
      step(); smp();
      dma_read(16'h030C, exp_mem[195]);
      $display("lock sequence done");

      // Reset right after a DMA read grant discards the return
      step(); clr();
      bus.dma_req = 1'b1; bus.dma_addr = 16'h0104;
      smp();
      chk("rstseq_gnt", 32'(bus.dma_gnt), 32'd1);
      step();
      rst = 1'b0;
      bus.cpu_req = 1'b1;
      #1;
      chk("rstseq_stall", 32'(bus.cpu_stall), 32'd0);
      chk("rstseq_ram_en", 32'(bus.ram_en), 32'd0);
      chk("rstseq_ram_we", 32'(bus.ram_we), 32'd0);
      chk("rstseq_gnt0", 32'(bus.dma_gnt), 32'd0);
      chk("rstseq_rvalid", 32'(bus.dma_rvalid), 32'd0);
      chk("rstseq_cpu_rdata", bus.cpu_rdata, 32'd0);
      chk("rstseq_dma_rdata", bus.dma_rdata, 32'd0);
      smp(); step(); smp();
      step(); clr();
      rst = 1'b1;
      smp(); step(); smp(); step(); smp();
      cpu_read(16'h0010, 32'hDEADBEEF);
      $display("reset sequence done");

      step(); clr(); smp(); smp();
      chk("cpu_sb_empty", 32'(cq.size()), 32'd0);
      chk("dma_sb_empty", 32'(dq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-RAM port between the CPU data port and a DMA/loader port (UART bootloader, future DMA engine).
- The RAM is synchronous: a read issued in cycle N returns data in cycle N+1.
- Sequences CPU stalls for read latency and for lost arbitration. Gives the CPU fixed priority, with a starvation guard for DMA.
- Sits between cpu_core/address decode (is_ram path) and the data_mem array in minisys_top.

Parameters:
- ADDR_W, 16, byte-address width of the RAM window (word address = ADDR_W-2 bits).
- MAX_CPU_STREAK, 4, consecutive CPU grants allowed while dma_req is pending before DMA is forced a slot (1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU RAM access this cycle (dmem access with is_ram)
- cpu_we  in  1  CPU write
- cpu_wstrb  in  4  CPU byte strobes
- cpu_addr  in  ADDR_W  CPU byte address
- cpu_wdata  in  32  CPU write data
- cpu_rdata  out  32  CPU read data
- cpu_stall  out  1  hold CPU pipeline/PC this cycle
- dma_lock  in  1  exclude CPU entirely (bootload)
- dma_req  in  1  DMA request, held until dma_gnt
- dma_we  in  1  DMA write
- dma_wstrb  in  4  DMA byte strobes
- dma_addr  in  ADDR_W  DMA byte address
- dma_wdata  in  32  DMA write data
- dma_gnt  out  1  one-cycle pulse: DMA request accepted this cycle
- dma_rvalid  out  1  DMA read data valid (cycle after a granted DMA read)
- dma_rdata  out  32  DMA read data
- ram_en  out  1  RAM access enable
- ram_we  out  4  RAM byte write enables
- ram_addr  out  ADDR_W-2  RAM word address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data (valid cycle after ram_en with ram_we=0)

Behaviour:
- Reset (rst=0, async):
  - cpu_stall=0, dma_gnt=0, dma_rvalid=0, ram_en=0, ram_we=0.
  - cpu_rdata=0, dma_rdata=0, streak=0, state=IDLE.
  - Any in-flight read return is discarded; no dma_rvalid after reset release.
- States:
  - IDLE: no CPU read outstanding.
  - CPU_RET: the cycle after a granted CPU read.
- Grant rule (combinational, per cycle):
  - In CPU_RET the CPU is never granted (its held request is the one returning). The port may go to DMA if dma_req.
  - In IDLE the CPU wins if cpu_req && !dma_lock && !(dma_req && streak==MAX_CPU_STREAK). Otherwise DMA wins if dma_req.
- Granted owner drives ram_en=1, ram_addr=addr[ADDR_W-1:2], ram_wdata, ram_we = wstrb if we else 4'b0.
- No grant: ram_en=0, ram_we=0.
- CPU write granted: completes that cycle, cpu_stall=0.
- CPU read granted: cpu_stall=1, next state CPU_RET.
- CPU_RET:
  - cpu_stall=0 and cpu_rdata=ram_rdata (combinational); the value is also captured and held until the next CPU read return.
  - Next state IDLE.
- cpu_req high but not granted (IDLE): cpu_stall=1, state stays IDLE.
- dma_gnt=1 in the DMA grant cycle. A DMA read asserts dma_rvalid=1 with dma_rdata=ram_rdata in the following cycle; dma_rdata is held afterwards.
- DMA may be granted in CPU_RET, so a CPU return and a DMA issue can coincide.
- Streak counter (4 bit):
  - Increments on each CPU grant while dma_req=1, saturating at MAX_CPU_STREAK.
  - Clears on a DMA grant or whenever dma_req=0.
- dma_lock=1: CPU requests stall indefinitely, but an already-issued CPU read still returns.
- Simultaneous CPU and DMA writes to the same word: only the granted one writes. The loser retries next cycle (last writer wins).
- Requests from both sides with neither eligible cannot occur: DMA is always eligible when the CPU is excluded.

Decomposition:
- Shared package minisys_mem_pkg:
  - RAM_ADDR_W default (16).
  - WSTRB_W=4.
  - Owner encoding OWN_NONE/OWN_CPU/OWN_DMA.
  - State encoding ARB_IDLE/ARB_CPU_RET.
- No sub-module: grant logic, streak counter and return tracking stay in one module.

Test Plan:
- CPU read 0x0010 (RAM word 4 = 0xDEADBEEF), no DMA -> cycle N: ram_en=1, ram_addr=4, cpu_stall=1; N+1: cpu_rdata=0xDEADBEEF, cpu_stall=0, ram_en=0.
- CPU write 0x0020, wstrb=4'b0011, wdata=0x12345678 -> same cycle ram_we=4'b0011, ram_addr=8, cpu_stall=0.
- CPU reads every cycle with dma_req held (DMA write 0x0100=0xA5A5A5A5), MAX_CPU_STREAK=4 -> DMA granted no later than the 5th CPU-eligible cycle; dma_gnt pulses exactly once; word 64 reads back 0xA5A5A5A5.
- CPU read issued, DMA read in its CPU_RET cycle -> that cycle: cpu_rdata valid, dma_gnt=1; next cycle: dma_rvalid=1 with the DMA word.
- dma_lock=1 with cpu_req=1 for 10 cycles while DMA streams 8 writes -> cpu_stall=1 throughout, 8 dma_gnt pulses; lock released -> CPU granted the next cycle.
- rst asserted in the cycle after a DMA read grant -> dma_rvalid never asserts; all outputs 0 immediately; after release the first CPU read behaves normally.
